instr_prefetch_fifo: RTL and testbench
======================================

INSTR_PREFETCH_FIFO -- requirements
Module: instr_prefetch_fifo

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter RESET_PC, default 32'h0, SHALL set the fetch address used after reset and after jtag reset.
REQ-003 Port clk_i, input, 1 bit: the single clock.
REQ-004 Port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port req_o, output, 1 bit: fetch request to the bus.
REQ-006 Port addr_o, output, 32 bits: fetch address.
REQ-007 Port ready_i, input, 1 bit: the bus has completed the request; data_i is valid this cycle.
REQ-008 Port data_i, input, 32 bits: fetched instruction word.
REQ-009 Port jump_flag_i, input, 1 bit: redirect the fetch stream.
REQ-010 Port jump_addr_i, input, 32 bits: redirect target.
REQ-011 Port jtag_reset_flag_i, input, 1 bit: redirect the fetch stream to RESET_PC.
REQ-012 Port hold_i, input, 1 bit: suppress issue of new requests.
REQ-013 Port valid_o, output, 1 bit: head entry is valid.
REQ-014 Port instr_o, output, 32 bits: head instruction.
REQ-015 Port pc_o, output, 32 bits: head instruction address.
REQ-016 Port pc_next_o, output, 32 bits: pc_o + 4.
REQ-017 Port ready_i_dn, input, 1 bit: downstream accepts the head entry.
REQ-018 Port level_o, output, $clog2(DEPTH)+1 bits: current entry count.

Function
REQ-019 The block SHALL have three states: IDLE (no request), FETCH (req_o high), DISCARD (req_o high; the returned word is dropped).
REQ-020 IDLE->FETCH SHALL occur when hold_i is low and level_o plus in-flight requests is less than DEPTH; at most one request SHALL be outstanding.
REQ-021 While req_o is high, addr_o SHALL stay stable until ready_i; a handshake is req_o and ready_i high in the same cycle.
REQ-022 On a FETCH handshake, the block SHALL push {data_i, addr_o} and advance the fetch pc by 4 (32-bit wrap at 32'hFFFF_FFFC to 0); FETCH->FETCH if space remains and hold_i is low, otherwise FETCH->IDLE.
REQ-023 A pop SHALL occur when valid_o and ready_i_dn are both high; push and pop in the same cycle SHALL leave level_o unchanged, including when the FIFO is full.
REQ-024 A push SHALL never occur when the FIFO is full; a pop SHALL never occur when it is empty; read and write pointers SHALL wrap modulo DEPTH.
REQ-025 A flush (jump_flag_i or jtag_reset_flag_i) SHALL, on the next edge, empty the FIFO (level_o=0, valid_o=0) and set the fetch pc to jump_addr_i, or to RESET_PC when jtag_reset_flag_i is set (jtag_reset_flag_i has priority).
REQ-026 A flush SHALL take priority over a push or pop in the same cycle.
REQ-027 A flush while in FETCH without ready_i SHALL move to DISCARD; the DISCARD handshake SHALL push nothing and go to IDLE, and the next request SHALL use the redirected pc.
REQ-028 A flush coinciding with a FETCH handshake SHALL drop data_i and go to IDLE.
REQ-029 hold_i SHALL block only new requests; a request already in flight SHALL complete normally.
REQ-030 Latency SHALL be one cycle from a handshake to valid_o for that word when the FIFO was empty (unless REQ-036 applies).

Reset
REQ-031 While rst_ni is low at a clock edge, the block SHALL set state IDLE, fetch pc RESET_PC, pointers 0, level_o 0.
REQ-032 The reset values of the outputs SHALL be: req_o 0, addr_o RESET_PC, valid_o 0, instr_o 0, pc_o 0, pc_next_o 4, level_o 0.
REQ-033 A reset asserted mid-request SHALL abandon the request without a push; the first request after release SHALL use RESET_PC.
REQ-034 FIFO storage SHALL not require reset; an empty FIFO SHALL drive instr_o 0 and pc_o 0.

Configuration
REQ-035 The macro PREFETCH_BYPASS_EN SHALL compile the bypass path in or out.
REQ-036 With PREFETCH_BYPASS_EN defined, when the FIFO is empty, a FETCH handshake occurs, and there is no flush, data_i and addr_o SHALL appear on instr_o/pc_o with valid_o high in the same cycle; if ready_i_dn is also high, the word SHALL be consumed without a push.
REQ-037 Without PREFETCH_BYPASS_EN, valid_o SHALL come only from registered FIFO state (REQ-030).

Verification
REQ-038 After reset, DEPTH=4, ready_i always 1, ready_i_dn 0: addr_o 0,4,8,C; level_o reaches 4; req_o drops; valid_o 1 with pc_o 0.
REQ-039 Full FIFO with ready_i_dn held 1: one pop per cycle and pc_o sequence 0,4,8,...; level_o stays at or below 4.
REQ-040 jump_flag_i=1, jump_addr_i=32'h100 while ready_i=0 in FETCH: state goes to DISCARD; the next handshake pushes nothing; the next addr_o is 32'h100; level_o is 0.
REQ-041 jtag_reset_flag_i and jump_flag_i asserted together with jump_addr_i=32'h200: the next addr_o is RESET_PC.
REQ-042 hold_i=1 during an in-flight request: that request completes and pushes; no further req_o until hold_i=0.
REQ-043 PREFETCH_BYPASS_EN defined, FIFO empty, handshake with data_i=32'h00000013 and ready_i_dn=1: valid_o=1 and instr_o=32'h13 in the same cycle, and level_o stays 0.

Source files
------------

// File: rtl/instr_prefetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : instr_prefetch_fifo
//  Purpose  : Instruction prefetch unit. It issues sequential 32-bit fetch
//             requests to a single-outstanding bus and buffers the returned
//             words, together with their addresses, in a small FIFO. The
//             fetch stream can be redirected by a jump or a jtag reset.
//             A redirect empties the FIFO. A request that is already on the
//             bus when a redirect arrives is completed and its data dropped.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH     number of FIFO entries (power of two, 2..16)
//    RESET_PC  fetch address used after reset / jtag reset
//  Ports
//    clk_i              clock
//    rst_ni             synchronous active-low reset
//    req_o / addr_o     bus fetch request and address (held until ready_i)
//    ready_i / data_i   bus completion and returned instruction word
//    jump_flag_i        redirect fetch stream to jump_addr_i
//    jump_addr_i        redirect target
//    jtag_reset_flag_i  redirect fetch stream to RESET_PC (wins over jump)
//    hold_i             block issue of new requests
//    valid_o            head entry valid
//    instr_o / pc_o     head instruction and its address
//    pc_next_o          pc_o + 4
//    ready_i_dn         downstream accepts the head entry
//    level_o            number of buffered entries
//  Build options
//    PREFETCH_BYPASS_EN  when defined, a word returning into an empty FIFO is
//                        presented on the outputs in the same cycle and is
//                        consumed without a push if ready_i_dn is high.
// ============================================================================
module instr_prefetch_fifo #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  // bus side
  output logic                     req_o,
  output logic [31:0]              addr_o,
  input  logic                     ready_i,
  input  logic [31:0]              data_i,
  // redirect / control
  input  logic                     jump_flag_i,
  input  logic [31:0]              jump_addr_i,
  input  logic                     jtag_reset_flag_i,
  input  logic                     hold_i,
  // downstream side
  output logic                     valid_o,
  output logic [31:0]              instr_o,
  output logic [31:0]              pc_o,
  output logic [31:0]              pc_next_o,
  input  logic                     ready_i_dn,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;               // address of current / next fetch
  logic [31:0]       disc_addr_q, disc_addr_d; // address of the abandoned request
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  // Storage is not reset; empty-FIFO outputs are forced to zero below.
  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       pc_mem_q    [DEPTH];

  logic              flush_w;
  logic [31:0]       flush_pc_w;
  logic              fetch_hs_w;
  logic              empty_w;
  logic              full_w;
  logic              bypass_w;
  logic              bypass_take_w;
  logic              push_w;
  logic              pop_w;

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  assign flush_w    = jump_flag_i | jtag_reset_flag_i;
  assign flush_pc_w = jtag_reset_flag_i ? RESET_PC : jump_addr_i;
  assign fetch_hs_w = (state_q == S_FETCH) && ready_i;
  assign empty_w    = (level_q == '0);
  assign full_w     = (level_q == DEPTH_L);

`ifdef PREFETCH_BYPASS_EN
  // Returning word goes straight to the outputs when nothing is buffered.
  assign bypass_w = fetch_hs_w && empty_w && !flush_w;
`else
  assign bypass_w = 1'b0;
`endif
  assign bypass_take_w = bypass_w && ready_i_dn;

  // A flush wins over any push or pop in the same cycle. A bypassed word that
  // is consumed immediately never enters the FIFO.
  assign push_w = fetch_hs_w && !flush_w && !full_w && !bypass_take_w;
  assign pop_w  = !empty_w && ready_i_dn && !flush_w;

  // --------------------------------------------------------------------------
  // FIFO pointer / level next-state
  // --------------------------------------------------------------------------
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_w) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_w) begin
        wptr_d = wptr_q + PTR_W'(1);
      end
      if (pop_w) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      case ({push_w, pop_w})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Fetch FSM next-state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    disc_addr_d = disc_addr_q;

    if (flush_w) begin
      pc_d = flush_pc_w;
    end

    case (state_q)
      S_IDLE: begin
        // Nothing is in flight here, so space means level below DEPTH; a
        // flush empties the FIFO, so space is guaranteed.
        if (!hold_i && (flush_w || (level_q < DEPTH_L))) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (ready_i) begin
          if (flush_w) begin
            // Data for the old stream is dropped.
            state_d = S_IDLE;
          end else begin
            pc_d = pc_q + 32'd4;
            // Keep fetching only if the next word is guaranteed a slot.
            if (!hold_i && (level_d < DEPTH_L)) begin
              state_d = S_FETCH;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (flush_w) begin
          // The bus still owns the old request: keep presenting its address
          // until it completes, then throw the data away.
          state_d     = S_DISCARD;
          disc_addr_d = pc_q;
        end
      end

      S_DISCARD: begin
        if (ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      disc_addr_q <= RESET_PC;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      disc_addr_q <= disc_addr_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && push_w) begin
      instr_mem_q[wptr_q] <= data_i;
      pc_mem_q[wptr_q]    <= pc_q;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req_o   = (state_q != S_IDLE);
  assign addr_o  = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
  assign level_o = level_q;

  always_comb begin
    valid_o = 1'b0;
    instr_o = 32'h0;
    pc_o    = 32'h0;
    if (bypass_w) begin
      valid_o = 1'b1;
      instr_o = data_i;
      pc_o    = pc_q;
    end else if (!empty_w) begin
      valid_o = 1'b1;
      instr_o = instr_mem_q[rptr_q];
      pc_o    = pc_mem_q[rptr_q];
    end
  end

  assign pc_next_o = pc_o + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_prefetch_fifo
//  Purpose  : Directed self-checking bench for instr_prefetch_fifo
//             (DEPTH=4, RESET_PC=0). The bus model returns addr ^ 32'h13.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_prefetch_fifo;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_o;
  logic [31:0] addr_o;
  logic        ready_i;
  logic [31:0] data_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        jtag_reset_flag_i;
  logic        hold_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_next_o;
  logic        ready_i_dn;
  logic [2:0]  level_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  // Bus memory model: word at address A is A ^ 32'h13 (address 0 -> 32'h13).
  assign data_i = addr_o ^ 32'h0000_0013;

  instr_prefetch_fifo #(
    .DEPTH   (4),
    .RESET_PC(32'h0)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_o            (req_o),
    .addr_o           (addr_o),
    .ready_i          (ready_i),
    .data_i           (data_i),
    .jump_flag_i      (jump_flag_i),
    .jump_addr_i      (jump_addr_i),
    .jtag_reset_flag_i(jtag_reset_flag_i),
    .hold_i           (hold_i),
    .valid_o          (valid_o),
    .instr_o          (instr_o),
    .pc_o             (pc_o),
    .pc_next_o        (pc_next_o),
    .ready_i_dn       (ready_i_dn),
    .level_o          (level_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; ready_i = 1'b0; jump_flag_i = 1'b0; jump_addr_i = 32'h0;
    jtag_reset_flag_i = 1'b0; hold_i = 1'b0; ready_i_dn = 1'b0;
    tick(); tick(); #2;

    // Reset values
    chk("rst_req",     {31'h0, req_o},   32'h0);
    chk("rst_addr",    addr_o,           32'h0);
    chk("rst_valid",   {31'h0, valid_o}, 32'h0);
    chk("rst_instr",   instr_o,          32'h0);
    chk("rst_pc",      pc_o,             32'h0);
    chk("rst_pc_next", pc_next_o,        32'h4);
    chk("rst_level",   {29'h0, level_o}, 32'h0);

    // Fill: ready_i always 1, downstream stalled
    rst_ni = 1'b1; ready_i = 1'b1;
    tick(); #2;
    for (int i = 0; i < 4; i++) begin
      chk("fill_req",  {31'h0, req_o}, 32'h1);
      chk("fill_addr", addr_o, 32'(i * 4));
      tick(); #2;
    end
    chk("full_level",   {29'h0, level_o}, 32'h4);
    chk("full_req",     {31'h0, req_o},   32'h0);
    chk("full_valid",   {31'h0, valid_o}, 32'h1);
    chk("full_pc",      pc_o,             32'h0);
    chk("full_instr",   instr_o,          32'h13);
    chk("full_pc_next", pc_next_o,        32'h4);
    tick(); #2;
    chk("full_stay_req",   {31'h0, req_o},   32'h0);
    chk("full_stay_level", {29'h0, level_o}, 32'h4);

    // Drain while refilling: one pop per cycle, continuous pc sequence
    ready_i_dn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_pc",    pc_o,    32'(i * 4));
      chk("drain_instr", instr_o, 32'(i * 4) ^ 32'h13);
      chk("drain_valid", {31'h0, valid_o}, 32'h1);
      chk("drain_level_le4", {31'h0, (level_o <= 3'd4)}, 32'h1);
      tick(); #2;
    end

    // Jump while request pending without ready -> DISCARD
    ready_i_dn = 1'b0; ready_i = 1'b0; #1;
    chk("pend_req",  {31'h0, req_o}, 32'h1);
    chk("pend_addr", addr_o, 32'h28);
    jump_flag_i = 1'b1; jump_addr_i = 32'h100;
    tick(); jump_flag_i = 1'b0; #2;
    chk("disc_level", {29'h0, level_o}, 32'h0);
    chk("disc_valid", {31'h0, valid_o}, 32'h0);
    chk("disc_req",   {31'h0, req_o},   32'h1);
    chk("disc_addr_stable", addr_o, 32'h28);
    ready_i = 1'b1;
    tick(); #2;
    chk("disc_done_level", {29'h0, level_o}, 32'h0);
    chk("disc_done_valid", {31'h0, valid_o}, 32'h0);
    chk("disc_done_req",   {31'h0, req_o},   32'h0);
    tick(); #2;
    chk("redir_req",  {31'h0, req_o}, 32'h1);
    chk("redir_addr", addr_o, 32'h100);
    tick(); #2;
    chk("redir_valid",   {31'h0, valid_o}, 32'h1);
    chk("redir_pc",      pc_o,             32'h100);
    chk("redir_instr",   instr_o,          32'h113);
    chk("redir_pc_next", pc_next_o,        32'h104);
    chk("redir_level",   {29'h0, level_o}, 32'h1);

    // jtag reset and jump together, coinciding with a handshake
    jtag_reset_flag_i = 1'b1; jump_flag_i = 1'b1; jump_addr_i = 32'h200;
    tick(); jtag_reset_flag_i = 1'b0; jump_flag_i = 1'b0; #2;
    chk("jtag_level", {29'h0, level_o}, 32'h0);
    chk("jtag_valid", {31'h0, valid_o}, 32'h0);
    chk("jtag_req",   {31'h0, req_o},   32'h0);
    chk("jtag_addr",  addr_o,           32'h0);

    // Handshake into empty FIFO with downstream ready
    ready_i_dn = 1'b1;
    tick(); #2;
    chk("empty_hs_req",  {31'h0, req_o}, 32'h1);
    chk("empty_hs_addr", addr_o, 32'h0);
`ifdef PREFETCH_BYPASS_EN
    chk("byp_valid", {31'h0, valid_o}, 32'h1);
    chk("byp_instr", instr_o,          32'h13);
    chk("byp_pc",    pc_o,             32'h0);
`else
    chk("nobyp_valid", {31'h0, valid_o}, 32'h0);
    chk("nobyp_instr", instr_o,          32'h0);
`endif
    chk("empty_hs_level", {29'h0, level_o}, 32'h0);
    tick(); ready_i = 1'b0; #2;
    chk("after_hs_req",  {31'h0, req_o}, 32'h1);
    chk("after_hs_addr", addr_o, 32'h4);
`ifdef PREFETCH_BYPASS_EN
    chk("byp_after_level", {29'h0, level_o}, 32'h0);
    chk("byp_after_valid", {31'h0, valid_o}, 32'h0);
`else
    chk("lat1_level", {29'h0, level_o}, 32'h1);
    chk("lat1_valid", {31'h0, valid_o}, 32'h1);
    chk("lat1_pc",    pc_o,             32'h0);
    chk("lat1_instr", instr_o,          32'h13);
`endif
    tick(); ready_i_dn = 1'b0; #2;
    chk("popped_level", {29'h0, level_o}, 32'h0);
    chk("popped_valid", {31'h0, valid_o}, 32'h0);

    // hold_i during an in-flight request
    hold_i = 1'b1;
    tick(); #2;
    chk("hold_inflight_req",  {31'h0, req_o}, 32'h1);
    chk("hold_inflight_addr", addr_o, 32'h4);
    ready_i = 1'b1;
    tick(); #2;
    chk("hold_done_req",   {31'h0, req_o},   32'h0);
    chk("hold_done_level", {29'h0, level_o}, 32'h1);
    chk("hold_done_pc",    pc_o,             32'h4);
    chk("hold_done_instr", instr_o,          32'h17);
    tick(); #2;
    chk("hold_idle_req1", {31'h0, req_o}, 32'h0);
    tick(); #2;
    chk("hold_idle_req2", {31'h0, req_o}, 32'h0);
    hold_i = 1'b0;
    tick(); #2;
    chk("unhold_req",  {31'h0, req_o}, 32'h1);
    chk("unhold_addr", addr_o, 32'h8);

    // Address wrap at 32'hFFFF_FFFC
    jump_flag_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
    tick(); jump_flag_i = 1'b0; #2;
    chk("wrapj_req",   {31'h0, req_o},   32'h0);
    chk("wrapj_level", {29'h0, level_o}, 32'h0);
    chk("wrapj_valid", {31'h0, valid_o}, 32'h0);
    tick(); #2;
    chk("wrap_req",  {31'h0, req_o}, 32'h1);
    chk("wrap_addr", addr_o, 32'hFFFF_FFFC);
    tick(); #2;
    chk("wrap_next_addr", addr_o,           32'h0);
    chk("wrap_pc",        pc_o,             32'hFFFF_FFFC);
    chk("wrap_pc_next",   pc_next_o,        32'h0);
    chk("wrap_instr",     instr_o,          32'hFFFF_FFEF);
    chk("wrap_level",     {29'h0, level_o}, 32'h1);

    // Reset in the middle of a request
    ready_i = 1'b0; rst_ni = 1'b0;
    tick(); #2;
    chk("midrst_req",   {31'h0, req_o},   32'h0);
    chk("midrst_level", {29'h0, level_o}, 32'h0);
    chk("midrst_valid", {31'h0, valid_o}, 32'h0);
    chk("midrst_addr",  addr_o,           32'h0);
    rst_ni = 1'b1; ready_i = 1'b1;
    tick(); #2;
    chk("postrst_req",  {31'h0, req_o}, 32'h1);
    chk("postrst_addr", addr_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
